// File: rtl/eq_pkg.sv
// Shared types, widths and pointer helpers for the FIR sample path.
package eq_pkg;

  localparam int unsigned SMPL_W = 16;

  typedef enum logic [1:0] {Q_IDLE, Q_PRIME, Q_SEQ} q_state_t;

  // Ring-pointer add with wrap; off must not exceed depth
  function automatic int unsigned ptr_add(input int unsigned base,
                                          input int unsigned off,
                                          input int unsigned depth);
    int unsigned sum;
    sum = base + off;
    return (sum >= depth) ? (sum - depth) : sum;
  endfunction

  // Ring-pointer increment with wrap depth-1 -> 0
  function automatic int unsigned ptr_inc(input int unsigned p,
                                          input int unsigned depth);
    return ptr_add(p, 32'd1, depth);
  endfunction

endpackage

// File: rtl/smpl_queue_if.sv
// Sample-in / replay-out bundle between the audio front end and the FIR core.
interface smpl_queue_if #(
  parameter int unsigned DW = 16
);
  logic                 wrt_smpl;
  logic signed [DW-1:0] new_smpl;
  logic signed [DW-1:0] smpl_out;
  logic                 sequencing;
  logic                 full;

  modport master (
    output wrt_smpl, new_smpl,
    input  smpl_out, sequencing, full
  );

  modport slave (
    input  wrt_smpl, new_smpl,
    output smpl_out, sequencing, full
  );
endinterface

// File: rtl/dp_ram_1r1w.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
module dp_ram_1r1w #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned DW    = 16,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Write and registered read; contents are never reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/smpl_queue.sv
// Circular sample history: stores audio samples and replays the last
// NUM_TAPS of them, oldest first, one per clk, framed by 'sequencing'.
module smpl_queue
  import eq_pkg::*;
#(
  parameter int unsigned NUM_TAPS = 1021,
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned DW       = SMPL_W
) (
  input  logic         clk,
  input  logic         rst_n,
  smpl_queue_if.slave  bus
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(NUM_TAPS + 1);

  q_state_t      state;
  logic [PW-1:0] new_ptr;
  logic [PW-1:0] old_ptr;
  logic [PW-1:0] rd_base;
  logic [CW-1:0] cnt;
  logic [CW-1:0] rd_cnt;
  logic          pend;
  logic          full_q;
  logic          seq_q;
  logic [DW-1:0] smpl_q;
  logic [DW-1:0] ram_q;

  logic [CW-1:0] cnt_nxt_c;
  logic [PW-1:0] raddr_c;
  logic          trig_c;
  logic          last_c;

  // Fill counter saturates once a full window is held
  always_comb begin
    cnt_nxt_c = cnt;
    if (bus.wrt_smpl && (cnt != CW'(NUM_TAPS))) begin
      cnt_nxt_c = cnt + CW'(1);
    end
  end

  assign trig_c = bus.wrt_smpl && (cnt_nxt_c == CW'(NUM_TAPS));
  assign last_c = (state == Q_SEQ) && (rd_cnt == CW'(NUM_TAPS - 1));

  // Read address: window start while priming, one ahead of rd_cnt while replaying
  always_comb begin
    raddr_c = old_ptr;
    if (state == Q_SEQ) begin
      raddr_c = PW'(ptr_add(32'(rd_base), 32'(rd_cnt) + 32'd1, DEPTH));
    end
  end

  dp_ram_1r1w #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .AW    (PW)
  ) u_ram (
    .clk   (clk),
    .we    (bus.wrt_smpl),
    .waddr (new_ptr),
    .wdata (bus.new_smpl),
    .raddr (raddr_c),
    .rdata (ram_q)
  );

  // Pointers, fill tracking, replay FSM and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= Q_IDLE;
      new_ptr <= '0;
      old_ptr <= '0;
      rd_base <= '0;
      cnt     <= '0;
      rd_cnt  <= '0;
      pend    <= 1'b0;
      full_q  <= 1'b0;
      seq_q   <= 1'b0;
      smpl_q  <= '0;
    end else begin
      if (bus.wrt_smpl) begin
        new_ptr <= PW'(ptr_inc(32'(new_ptr), DEPTH));
      end
      // Window tail only moves once the history is full
      if (bus.wrt_smpl && full_q) begin
        old_ptr <= PW'(ptr_inc(32'(old_ptr), DEPTH));
      end
      cnt <= cnt_nxt_c;
      if (cnt_nxt_c == CW'(NUM_TAPS)) begin
        full_q <= 1'b1;
      end

      // RAM output lags the read address by one clk, so outputs trail SEQ by one
      seq_q <= (state == Q_SEQ);
      if (state == Q_SEQ) begin
        smpl_q <= ram_q;
      end

      case (state)
        Q_IDLE: begin
          if (trig_c) begin
            state <= Q_PRIME;
          end
        end
        Q_PRIME: begin
          rd_base <= old_ptr;
          rd_cnt  <= '0;
          state   <= Q_SEQ;
          if (trig_c) begin
            pend <= 1'b1;
          end
        end
        Q_SEQ: begin
          if (last_c) begin
            // A write on the final cycle still earns a follow-up replay
            state <= (pend || trig_c) ? Q_PRIME : Q_IDLE;
            pend  <= 1'b0;
          end else begin
            rd_cnt <= rd_cnt + CW'(1);
            if (trig_c) begin
              pend <= 1'b1;
            end
          end
        end
        default: state <= Q_IDLE;
      endcase
    end
  end

  assign bus.smpl_out   = smpl_q;
  assign bus.sequencing = seq_q;
  assign bus.full       = full_q;

endmodule

// File: tb/tb_smpl_queue.sv
// Scoreboard bench for smpl_queue: small instance (4 taps, 6 deep) for
// directed cases and a default-sized instance for a long signed run.
module tb_smpl_queue;
  import eq_pkg::*;

  localparam int unsigned NA = 4;
  localparam int unsigned DA = 6;
  localparam int unsigned NB = 1021;
  localparam int unsigned DB = 1024;
  localparam int BUDGET = 3000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;

  int exp_a[$];
  int exp_b[$];
  int hist_a[$];
  int hist_b[$];
  int run_a = 0;
  int low_a = 0;
  int gap_a = 0;
  int run_b = 0;

  always #5 clk = ~clk;

  smpl_queue_if #(.DW(16)) bus_a ();
  smpl_queue_if #(.DW(16)) bus_b ();

  smpl_queue #(.NUM_TAPS(NA), .DEPTH(DA), .DW(16)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  smpl_queue #(.NUM_TAPS(NB), .DEPTH(DB), .DW(16)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int val_b(input int i);
    if (i % 5 == 0) return -32768;
    if (i % 5 == 1) return 32767;
    return ((i * 997) % 65536) - 32768;
  endfunction

  // Monitor A: pops one expected sample per sequencing cycle, checks run length
  always @(negedge clk) begin : mon_a
    int e;
    if (!rst_n) begin
      run_a = 0;
      low_a = 0;
    end else if (bus_a.sequencing) begin
      if (run_a == 0) gap_a = low_a;
      run_a++;
      checks++;
      if (exp_a.size() == 0) begin
        errors++;
        $display("FAIL a_extra_sample: got %0d with no replay expected at %0t",
                 int'($signed(bus_a.smpl_out)), $time);
      end else begin
        e = exp_a.pop_front();
        if (int'($signed(bus_a.smpl_out)) != e) begin
          errors++;
          $display("FAIL a_smpl: got %0d expected %0d at %0t",
                   int'($signed(bus_a.smpl_out)), e, $time);
        end
      end
    end else begin
      if (run_a != 0) begin
        chk("a_seq_len", run_a, NA);
        run_a = 0;
        low_a = 0;
      end
      low_a++;
    end
  end

  // Monitor B: same scoreboard for the full-size instance
  always @(negedge clk) begin : mon_b
    int e;
    if (!rst_n) begin
      run_b = 0;
    end else if (bus_b.sequencing) begin
      run_b++;
      checks++;
      if (exp_b.size() == 0) begin
        errors++;
        $display("FAIL b_extra_sample: got %0d with no replay expected at %0t",
                 int'($signed(bus_b.smpl_out)), $time);
      end else begin
        e = exp_b.pop_front();
        if (int'($signed(bus_b.smpl_out)) != e) begin
          errors++;
          $display("FAIL b_smpl: got %0d expected %0d at %0t",
                   int'($signed(bus_b.smpl_out)), e, $time);
        end
      end
    end else if (run_b != 0) begin
      chk("b_seq_len", run_b, NB);
      run_b = 0;
    end
  end

  task automatic wr_a(input int v);
    bus_a.new_smpl = 16'(v);
    bus_a.wrt_smpl = 1'b1;
    hist_a.push_back(v);
    tick(1);
    bus_a.wrt_smpl = 1'b0;
  endtask

  task automatic push_win_a();
    for (int i = hist_a.size() - NA; i < hist_a.size(); i++) exp_a.push_back(hist_a[i]);
  endtask

  task automatic push_win_b();
    for (int i = hist_b.size() - NB; i < hist_b.size(); i++) exp_b.push_back(hist_b[i]);
  endtask

  task automatic wait_seq_a(input logic lvl, input string what);
    int n = 0;
    while (bus_a.sequencing !== lvl && n < BUDGET) begin tick(1); n++; end
    checks++;
    if (bus_a.sequencing !== lvl) begin
      errors++;
      $display("FAIL %s: sequencing still %0b, required %0b", what, bus_a.sequencing, lvl);
    end
  endtask

  task automatic wait_seq_b(input logic lvl, input string what);
    int n = 0;
    while (bus_b.sequencing !== lvl && n < BUDGET) begin tick(1); n++; end
    checks++;
    if (bus_b.sequencing !== lvl) begin
      errors++;
      $display("FAIL %s: sequencing still %0b, required %0b", what, bus_b.sequencing, lvl);
    end
  endtask

  task automatic wait_idle_a(input string what);
    int n = 0;
    while ((exp_a.size() != 0 || bus_a.sequencing) && n < BUDGET) begin tick(1); n++; end
    chk(what, exp_a.size(), 0);
  endtask

  task automatic wait_idle_b(input string what);
    int n = 0;
    while ((exp_b.size() != 0 || bus_b.sequencing) && n < BUDGET) begin tick(1); n++; end
    chk(what, exp_b.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bus_a.wrt_smpl = 1'b0;
    bus_a.new_smpl = '0;
    bus_b.wrt_smpl = 1'b0;
    bus_b.new_smpl = '0;
    tick(3);
    chk("rst_seq", int'(bus_a.sequencing), 0);
    chk("rst_full", int'(bus_a.full), 0);
    chk("rst_smpl", int'($signed(bus_a.smpl_out)), 0);
    rst_n = 1'b1;
    tick(2);

    // 1: partial fill never triggers
    wr_a(1); chk("t1_full_1", int'(bus_a.full), 0); tick(20);
    wr_a(2); chk("t1_full_2", int'(bus_a.full), 0); tick(20);
    wr_a(3); chk("t1_full_3", int'(bus_a.full), 0); tick(20);
    chk("t1_seq", int'(bus_a.sequencing), 0);

    // 2: filling write, latency and first replay
    wr_a(4);
    push_win_a();
    chk("t2_full", int'(bus_a.full), 1);
    chk("t2_seq_e0", int'(bus_a.sequencing), 0);
    tick(1);
    chk("t2_seq_e1", int'(bus_a.sequencing), 0);
    tick(1);
    chk("t2_seq_e2", int'(bus_a.sequencing), 1);
    wait_idle_a("t2_idle");
    tick(5);

    // 3: steady state with pointer and rd_base wrap
    wr_a(5); push_win_a(); wait_idle_a("t3_idle_5"); tick(5);
    wr_a(6); push_win_a(); wait_idle_a("t3_idle_6"); tick(5);
    chk("t3_full", int'(bus_a.full), 1);
    wr_a(7); push_win_a();

    // 4: write mid-replay, then two writes collapse into one replay
    tick(3);
    chk("t4_seq_mid", int'(bus_a.sequencing), 1);
    wr_a(8); push_win_a();
    wait_seq_a(1'b0, "t4_fall");
    wait_seq_a(1'b1, "t4_rise");
    tick(1);
    chk("t4_gap", gap_a, 1);
    wr_a(9);
    wr_a(10);
    push_win_a();
    wait_idle_a("t4_idle");
    tick(20);
    chk("t4_no_extra", int'(bus_a.sequencing), 0);

    // 5: asynchronous reset during a replay, then refill
    wr_a(11); push_win_a();
    tick(4);
    rst_n = 1'b0;
    #1;
    chk("t5_seq", int'(bus_a.sequencing), 0);
    chk("t5_full", int'(bus_a.full), 0);
    chk("t5_smpl", int'($signed(bus_a.smpl_out)), 0);
    exp_a.delete();
    hist_a.delete();
    tick(2);
    rst_n = 1'b1;
    tick(2);
    wr_a(21); tick(3);
    wr_a(22); tick(3);
    wr_a(23); tick(3);
    chk("t5_full_pre", int'(bus_a.full), 0);
    wr_a(24); push_win_a();
    chk("t5_full_post", int'(bus_a.full), 1);
    wait_idle_a("t5_idle");

    // 6: default size, signed extremes, 1100 writes
    k = 0;
    for (int i = 0; i < int'(NB); i++) begin
      if (i == int'(NB) - 1) chk("t6_full_pre", int'(bus_b.full), 0);
      bus_b.new_smpl = 16'(val_b(k));
      bus_b.wrt_smpl = 1'b1;
      hist_b.push_back(val_b(k));
      k++;
      tick(1);
    end
    bus_b.wrt_smpl = 1'b0;
    push_win_b();
    chk("t6_full_post", int'(bus_b.full), 1);
    for (int r = 0; r < 26; r++) begin
      wait_seq_b(1'b1, "t6_rise");
      tick(1);
      for (int j = 0; j < 3; j++) begin
        bus_b.new_smpl = 16'(val_b(k));
        bus_b.wrt_smpl = 1'b1;
        hist_b.push_back(val_b(k));
        k++;
        tick(1);
      end
      bus_b.wrt_smpl = 1'b0;
      push_win_b();
      wait_seq_b(1'b0, "t6_fall");
    end
    wait_idle_b("t6_idle_chain");
    tick(5);
    bus_b.new_smpl = 16'(val_b(k));
    bus_b.wrt_smpl = 1'b1;
    hist_b.push_back(val_b(k));
    k++;
    tick(1);
    bus_b.wrt_smpl = 1'b0;
    push_win_b();
    wait_idle_b("t6_idle_last");
    chk("t6_writes", k, 1100);
    tick(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
